// File: rtl/mem_wb_skid_pkg.sv
// mem_wb_skid_pkg: shared constants for the LSU->WB skid pipeline register
package mem_wb_skid_pkg;
  localparam logic RstEnable = 1'b0;
  localparam logic WriteDisable = 1'b0;
  localparam logic [31:0] ZeroWord = 32'h0;
  localparam int RegBus = 32;
  localparam int WB_MAX_LANES = 4;
endpackage

// File: rtl/mem_wb_skid_payload_slot.sv
// wb_payload_slot: one valid bit plus payload register; clear wins over load and zeroes the payload
module wb_payload_slot
  import mem_wb_skid_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         n_rst_i,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);
  always_ff @(posedge clk_i or negedge n_rst_i)
    if (n_rst_i == RstEnable) begin
      valid <= 1'b0;
      q <= '0;
    end else if (clr) begin
      valid <= 1'b0;
      q <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q <= d;
    end
endmodule

// File: rtl/mem_wb_skid.sv
// mem_wb_skid: LSU->WB multi-lane pipeline register with valid/ready and 2-entry skid buffer.
// Define RETIRE_TRACE_EN to carry pc/instr trace payload and expose trace ports.
module mem_wb_skid
  import mem_wb_skid_pkg::*;
#(
  parameter int XLEN = RegBus,
  parameter int LANES = 2,
  parameter int RA_W = 5
) (
  input  logic                       clk_i,
  input  logic                       n_rst_i,
  input  logic                       flush_i,
  input  logic                       up_valid_i,
  output logic                       up_ready_o,
  input  logic [LANES-1:0]           lane_vld_i,
  input  logic [LANES-1:0]           rd_we_i,
  input  logic [LANES*RA_W-1:0]      rd_addr_i,
  input  logic [LANES*XLEN-1:0]      rd_wdata_i,
  input  logic                       csr_we_i,
  input  logic [11:0]                csr_waddr_i,
  input  logic [XLEN-1:0]            csr_wdata_i,
  output logic                       wb_valid_o,
  input  logic                       wb_ready_i,
  output logic [LANES-1:0]           rd_we_o,
  output logic [LANES*RA_W-1:0]      rd_addr_o,
  output logic [LANES*XLEN-1:0]      rd_wdata_o,
  output logic                       csr_we_o,
  output logic [11:0]                csr_waddr_o,
  output logic [XLEN-1:0]            csr_wdata_o,
`ifdef RETIRE_TRACE_EN
  input  logic [LANES*XLEN-1:0]      pc_i,
  input  logic [LANES*32-1:0]        instr_i,
  output logic [LANES*XLEN-1:0]      pc_o,
  output logic [LANES*32-1:0]        instr_o,
  output logic [LANES-1:0]           trace_vld_o,
`endif
  output logic [$clog2(LANES+1)-1:0] instret_incr_o
);
  localparam int CW = $clog2(LANES+1);
`ifdef RETIRE_TRACE_EN
  localparam int TW = LANES*(XLEN+32);
`else
  localparam int TW = 0;
`endif
  localparam int BW = LANES*(2+RA_W+XLEN) + 13 + XLEN + TW;
  function automatic logic [CW-1:0] popcount(input logic [LANES-1:0] v);
    popcount = '0;
    for (int i = 0; i < LANES; i++) popcount = popcount + CW'(v[i]);
  endfunction
  logic accept, drain, m_valid, s_valid, m_from_s, m_load, m_clr, s_load, s_clr;
  logic [BW-1:0] in_d, m_d, m_q, s_q;
  logic [LANES-1:0] m_lane_vld, m_rd_we;
  logic m_csr_we;
`ifdef RETIRE_TRACE_EN
  assign in_d = {instr_i, pc_i, lane_vld_i, rd_we_i, rd_addr_i, rd_wdata_i, csr_we_i, csr_waddr_i, csr_wdata_i};
  assign {instr_o, pc_o} = m_q[BW-1:BW-TW];
  assign trace_vld_o = drain ? m_lane_vld : '0;
`else
  assign in_d = {lane_vld_i, rd_we_i, rd_addr_i, rd_wdata_i, csr_we_i, csr_waddr_i, csr_wdata_i};
`endif
  assign {m_lane_vld, m_rd_we, rd_addr_o, rd_wdata_o, m_csr_we, csr_waddr_o, csr_wdata_o} = m_q[BW-TW-1:0];
  assign accept = up_valid_i & up_ready_o;
  assign drain = m_valid & wb_ready_i;
  // S refills M on drain; accept cannot coincide because up_ready_o tracks ~S.valid
  assign m_from_s = drain & s_valid;
  assign m_load = m_from_s | (accept & (~m_valid | drain));
  assign m_clr = flush_i | (drain & ~m_load);
  assign s_load = accept & m_valid & ~drain;
  assign s_clr = flush_i | m_from_s;
  assign m_d = m_from_s ? s_q : in_d;
  wb_payload_slot #(.W(BW)) u_m (
    .clk_i(clk_i), .n_rst_i(n_rst_i), .load(m_load), .clr(m_clr), .d(m_d), .valid(m_valid), .q(m_q)
  );
  wb_payload_slot #(.W(BW)) u_s (
    .clk_i(clk_i), .n_rst_i(n_rst_i), .load(s_load), .clr(s_clr), .d(in_d), .valid(s_valid), .q(s_q)
  );
  always_ff @(posedge clk_i or negedge n_rst_i)
    if (n_rst_i == RstEnable) up_ready_o <= 1'b1;
    else up_ready_o <= ~(~s_clr & (s_load | s_valid));
  assign wb_valid_o = m_valid;
  assign rd_we_o = m_valid ? (m_lane_vld & m_rd_we) : {LANES{WriteDisable}};
  assign csr_we_o = m_valid ? (m_lane_vld[0] & m_csr_we) : WriteDisable;
  assign instret_incr_o = drain ? popcount(m_lane_vld) : '0;
endmodule

// File: tb/tb_mem_wb_skid.sv
// tb_mem_wb_skid: directed self-checking bench for mem_wb_skid (LANES=2, XLEN=32, RA_W=5)
module tb_mem_wb_skid;
  logic clk = 0, n_rst = 0, flush = 0, up_valid = 0, up_ready, wb_valid, wb_ready = 0;
  logic [1:0] lane_vld = 0, rd_we = 0, rd_we_o, instret;
  logic [9:0] rd_addr = 0, rd_addr_o;
  logic [63:0] rd_wdata = 0, rd_wdata_o;
  logic csr_we = 0, csr_we_o;
  logic [11:0] csr_waddr = 0, csr_waddr_o;
  logic [31:0] csr_wdata = 0, csr_wdata_o;
`ifdef RETIRE_TRACE_EN
  logic [63:0] pc = 0, pc_o, instr = 0, instr_o;
  logic [1:0] trace_vld;
`endif
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  mem_wb_skid #(.XLEN(32), .LANES(2), .RA_W(5)) dut (
    .clk_i(clk), .n_rst_i(n_rst), .flush_i(flush), .up_valid_i(up_valid), .up_ready_o(up_ready),
    .lane_vld_i(lane_vld), .rd_we_i(rd_we), .rd_addr_i(rd_addr), .rd_wdata_i(rd_wdata),
    .csr_we_i(csr_we), .csr_waddr_i(csr_waddr), .csr_wdata_i(csr_wdata),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .rd_we_o(rd_we_o), .rd_addr_o(rd_addr_o),
    .rd_wdata_o(rd_wdata_o), .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
`ifdef RETIRE_TRACE_EN
    .pc_i(pc), .instr_i(instr), .pc_o(pc_o), .instr_o(instr_o), .trace_vld_o(trace_vld),
`endif
    .instret_incr_o(instret)
  );
  task automatic set_beat(input logic v, input logic [1:0] lv, input logic [1:0] we, input logic [31:0] d0);
    up_valid = v;
    lane_vld = lv;
    rd_we = we;
    rd_wdata = {d0 + 32'h1000, d0};
    rd_addr = {d0[4:0] + 5'd1, d0[4:0]};
    csr_we = 0;
    csr_waddr = 0;
    csr_wdata = 0;
  endtask
  task automatic fill_two(input logic [31:0] a, input logic [31:0] b);
    wb_ready = 0;
    @(negedge clk) set_beat(1, 2'b11, 2'b11, a);
    @(negedge clk) set_beat(1, 2'b11, 2'b11, b);
    @(negedge clk) set_beat(0, 2'b00, 2'b00, 0);
  endtask
  task automatic test_reset;
    @(negedge clk);
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid got=%b exp=0", wb_valid); end
    checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL rst_up_ready got=%b exp=1", up_ready); end
    checks++; if ({rd_we_o, rd_addr_o, rd_wdata_o, csr_we_o, csr_waddr_o, csr_wdata_o, instret} !== '0) begin
      errors++; $display("FAIL rst_outputs got=%h/%h/%h/%b exp=0", rd_we_o, rd_addr_o, rd_wdata_o, csr_we_o); end
    n_rst = 1;
  endtask
  task automatic test_back_to_back;
    int drains = 0, sum = 0, exp_i = 0;
    wb_ready = 1;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      if (wb_valid) begin
        checks++; if (rd_wdata_o[31:0] !== 32'h100 + exp_i) begin
          errors++; $display("FAIL b2b_order got=%h exp=%h", rd_wdata_o[31:0], 32'h100 + exp_i); end
        drains++; sum += int'(instret); exp_i++;
      end
      if (k < 10) begin
        checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL b2b_up_ready k=%0d got=%b exp=1", k, up_ready); end
      end
      set_beat(k < 10, 2'b11, 2'b11, 32'h100 + k);
    end
    @(negedge clk);
    checks++; if (drains != 10) begin errors++; $display("FAIL b2b_drains got=%0d exp=10", drains); end
    checks++; if (sum != 20) begin errors++; $display("FAIL b2b_instret_sum got=%0d exp=20", sum); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got=%b exp=0", wb_valid); end
  endtask
  task automatic test_stall;
    wb_ready = 0;
    @(negedge clk) set_beat(1, 2'b11, 2'b11, 32'hA0);
    @(negedge clk) set_beat(1, 2'b11, 2'b11, 32'hB0);
    @(negedge clk) set_beat(1, 2'b11, 2'b11, 32'hC0);
    for (int c = 0; c < 2; c++) begin
      checks++; if (up_ready !== 1'b0) begin errors++; $display("FAIL stall_up_ready c=%0d got=%b exp=0", c, up_ready); end
      checks++; if (wb_valid !== 1'b1 || rd_wdata_o[31:0] !== 32'hA0) begin
        errors++; $display("FAIL stall_hold_A c=%0d got=%b/%h exp=1/a0", c, wb_valid, rd_wdata_o[31:0]); end
      checks++; if (instret !== 2'd0) begin errors++; $display("FAIL stall_instret got=%0d exp=0", instret); end
      @(negedge clk);
    end
    set_beat(0, 2'b00, 2'b00, 0);
    wb_ready = 1;
    #1;
    checks++; if (instret !== 2'd2) begin errors++; $display("FAIL release_instret got=%0d exp=2", instret); end
    @(negedge clk);
    checks++; if (wb_valid !== 1'b1 || rd_wdata_o[31:0] !== 32'hB0) begin
      errors++; $display("FAIL release_B got=%b/%h exp=1/b0", wb_valid, rd_wdata_o[31:0]); end
    checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL release_up_ready got=%b exp=1", up_ready); end
    @(negedge clk);
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL release_empty got=%b exp=0", wb_valid); end
  endtask
  task automatic test_lane_mask;
    wb_ready = 1;
    @(negedge clk) begin set_beat(1, 2'b10, 2'b11, 32'h55); csr_we = 1; end
    @(negedge clk) set_beat(0, 2'b00, 2'b00, 0);
    #1;
    checks++; if (rd_we_o !== 2'b10) begin errors++; $display("FAIL lane_rd_we got=%b exp=10", rd_we_o); end
    checks++; if (instret !== 2'd1) begin errors++; $display("FAIL lane_instret got=%0d exp=1", instret); end
    checks++; if (csr_we_o !== 1'b0) begin errors++; $display("FAIL lane_csr_masked got=%b exp=0", csr_we_o); end
    checks++; if (rd_addr_o !== {5'h16, 5'h15}) begin errors++; $display("FAIL lane_addr got=%h exp=%h", rd_addr_o, {5'h16, 5'h15}); end
    @(negedge clk);
  endtask
  task automatic test_csr;
    int hits = 0;
    wb_ready = 0;
    @(negedge clk) begin set_beat(1, 2'b01, 2'b00, 0); csr_we = 1; csr_waddr = 12'h300; csr_wdata = 32'h8; end
    @(negedge clk) set_beat(0, 2'b00, 2'b00, 0);
    checks++; if (csr_we_o !== 1'b1 || csr_waddr_o !== 12'h300 || csr_wdata_o !== 32'h8) begin
      errors++; $display("FAIL csr_present got=%b/%h/%h exp=1/300/8", csr_we_o, csr_waddr_o, csr_wdata_o); end
    wb_ready = 1;
    for (int c = 0; c < 4; c++) begin
      #1 if (csr_we_o && wb_valid && wb_ready) hits++;
      @(negedge clk);
    end
    checks++; if (hits != 1) begin errors++; $display("FAIL csr_drain_cycles got=%0d exp=1", hits); end
    checks++; if (csr_waddr_o !== 12'h0) begin errors++; $display("FAIL csr_cleared got=%h exp=0", csr_waddr_o); end
  endtask
  task automatic test_flush;
    fill_two(32'hF0, 32'hF1);
    set_beat(1, 2'b11, 2'b11, 32'hF2);
    flush = 1;
    @(negedge clk) begin flush = 0; set_beat(0, 2'b00, 2'b00, 0); end
    checks++; if (wb_valid !== 1'b0 || up_ready !== 1'b1) begin
      errors++; $display("FAIL flush_state got=%b/%b exp=0/1", wb_valid, up_ready); end
    checks++; if (rd_addr_o !== '0 || rd_wdata_o !== '0) begin
      errors++; $display("FAIL flush_payload got=%h/%h exp=0", rd_addr_o, rd_wdata_o); end
    wb_ready = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (wb_valid !== 1'b0 || rd_we_o !== 2'b00 || csr_we_o !== 1'b0) begin
        errors++; $display("FAIL flush_no_writes c=%0d got=%b/%b/%b exp=0", c, wb_valid, rd_we_o, csr_we_o); end
    end
    set_beat(1, 2'b11, 2'b11, 32'hD0);
    @(negedge clk) begin set_beat(0, 2'b00, 2'b00, 0); flush = 1; end
    #1;
    checks++; if (instret !== 2'd2) begin errors++; $display("FAIL flush_drain_counts got=%0d exp=2", instret); end
    @(negedge clk) flush = 0;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL flush_drain_empty got=%b exp=0", wb_valid); end
  endtask
  task automatic test_reset_mid;
    fill_two(32'hE0, 32'hE1);
    checks++; if (up_ready !== 1'b0 || wb_valid !== 1'b1) begin
      errors++; $display("FAIL mid_full got=%b/%b exp=0/1", up_ready, wb_valid); end
    n_rst = 0;
    #1;
    checks++; if (wb_valid !== 1'b0 || up_ready !== 1'b1) begin
      errors++; $display("FAIL mid_rst_state got=%b/%b exp=0/1", wb_valid, up_ready); end
    @(negedge clk);
    checks++; if ({rd_we_o, rd_addr_o, rd_wdata_o, csr_we_o, csr_waddr_o, csr_wdata_o, instret} !== '0) begin
      errors++; $display("FAIL mid_rst_outputs got=%h/%h/%h exp=0", rd_we_o, rd_addr_o, rd_wdata_o); end
    n_rst = 1;
    @(negedge clk);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_lane_mask();
    test_csr();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
